instruction_cache_assoc: RTL
============================

# instruction_cache_assoc

Parametrised N-way set-associative instruction cache, successor to the direct-mapped instruction cache. Sits between the fetch stage and the bus/memory controller. Serves line reads on hit with one-cycle latency, runs its own miss FSM with a fill handshake, replaces by invalid-first then per-set round-robin, and supports single-cycle flush of all valid bits.

## Interface
- ADDR_WIDTH, 32, byte address width
- LINE_WIDTH, 128, cache line width in bits
- INDEX_WIDTH, 8, set index bits
- OFFSET_WIDTH, 4, byte offset bits; TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
- WAYS, 2, associativity; power of two, 1..8

- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request
- req_address  in  ADDR_WIDTH  fetch byte address
- req_ready  out  1  request accepted when req_valid && req_ready
- resp_valid  out  1  one-cycle response strobe; no backpressure
- resp_data  out  LINE_WIDTH  line containing requested address
- resp_hit  out  1  1 = served from cache, 0 = served from fill
- fill_request  out  1  miss outstanding, held until fill_valid
- fill_address  out  ADDR_WIDTH  line-aligned miss address (offset bits zero)
- fill_valid  in  1  one-cycle strobe, fill_data valid
- fill_data  in  LINE_WIDTH  line from memory
- flush  in  1  invalidate all lines

## Operation
- States: IDLE, LOOKUP, MISS, RESPOND.
- IDLE: req_ready=1; on accept, register address, issue tag/data RAM read for index on all ways -> LOOKUP.
- LOOKUP: way w hits if valid[set][w] && tag_w == registered tag. Hit: resp_valid=1, resp_hit=1, resp_data = hitting way's line; req_ready=1, a new accepted request stays in LOOKUP (back-to-back, one per cycle), else -> IDLE. Miss: req_ready=0 -> MISS. Multiple hitting ways is impossible by construction; lowest way wins if forced.
- MISS: fill_request=1, fill_address stable, req_ready=0. On fill_valid: write fill_data and tag to victim way, set its valid bit, register fill_data -> RESPOND.
- RESPOND: resp_valid=1, resp_hit=0, resp_data = registered fill line -> IDLE.
- Victim: lowest-numbered invalid way; if all valid, per-set round-robin pointer (clog2(WAYS) bits, flops), incremented modulo WAYS on every fill to that set.
- flush: clears all valid bits and round-robin pointers next edge. Flush in LOOKUP forces miss for that lookup. Flush during MISS: fill still accepted and returned, but line not marked valid. Flush with simultaneous fill write: flush wins.
- fill_valid outside MISS is ignored.
- Reset: state IDLE, all valid bits and pointers 0; RAM contents undefined and irrelevant. Reset mid-MISS drops the miss; a later fill_valid is ignored.

## Timing
- Reset values: req_ready=0 during reset, 1 in IDLE after; resp_valid=0, resp_hit=0, resp_data=0, fill_request=0, fill_address=0.
- Hit latency: accept at edge N, resp_valid high in cycle N+1.
- Miss latency: fill_request rises in cycle N+2; response one cycle after fill_valid.
- Throughput: one hit per cycle sustained.
- RAMs: synchronous read, one-cycle; write and read to same set never overlap (writes only in MISS).

## Structure
- Shared package: state enum typedef, TAG_WIDTH/way-index width helpers.
- Sub-module instruction_cache_way: one way's tag RAM + data RAM (dual_port_ram_mf, port B tied off) plus tag compare; top instantiates WAYS copies by generate. Valid bits, pointers, FSM in top.

## Test plan
- Reset then req 0x0000_1230 -> MISS, fill_address 0x0000_1230; fill_data 0xA5.. -> resp_hit=0, data 0xA5..; repeat req -> resp_hit=1 one cycle after accept.
- WAYS=2: fill tags 0x00001, 0x00011 at set 0x23 both hit; third tag 0x00021 evicts way 0 (tag 0x00001), which then misses while 0x00011 still hits.
- Back-to-back hits to 4 cached lines on consecutive cycles -> 4 consecutive resp_valid, req_ready never drops.
- flush after fills -> every prior address misses; flush during MISS -> response returned, re-request misses.
- reset_n low during MISS, then fill_valid -> ignored, no resp_valid, state IDLE, re-request misses.
- WAYS=1 and WAYS=8 builds pass hit/miss/eviction sequences with round-robin order 0..7.

Source files
------------

// File: rtl/instruction_cache_assoc_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package instruction_cache_assoc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      MISS    = 2'd2,
      RESPOND = 2'd3
   } state_t;

   function automatic int tag_width(int addr_width, int index_width, int offset_width);
      return addr_width - index_width - offset_width;
   endfunction

   // A single-way build still needs a 1-bit pointer so the arrays stay legal.
   function automatic int way_index_width(int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/instruction_cache_assoc_if.sv
// Fetch-side request/response and memory-side fill handshake of the cache.
interface instruction_cache_assoc_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
);

   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_address;
   logic                  req_ready;
   logic                  resp_valid;
   logic [LINE_WIDTH-1:0] resp_data;
   logic                  resp_hit;
   logic                  fill_request;
   logic [ADDR_WIDTH-1:0] fill_address;
   logic                  fill_valid;
   logic [LINE_WIDTH-1:0] fill_data;
   logic                  flush;

   modport slave (
      input  req_valid, req_address, fill_valid, fill_data, flush,
      output req_ready, resp_valid, resp_data, resp_hit, fill_request, fill_address
   );

   modport master (
      output req_valid, req_address, fill_valid, fill_data, flush,
      input  req_ready, resp_valid, resp_data, resp_hit, fill_request, fill_address
   );

endinterface

// File: rtl/dual_port_ram_mf.sv
// Generic two-port synchronous RAM, one-cycle registered read on each port.
module dual_port_ram_mf #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic                  a_we,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic                  b_we,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic [DATA_WIDTH-1:0] b_rdata
);

   logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] a_rdata_q;
   logic [DATA_WIDTH-1:0] b_rdata_q;

   // Contents are deliberately not reset; owners track validity separately.
   always_ff @(posedge clock) begin
      if (a_we) begin
         mem[a_addr] <= a_wdata;
      end
      if (b_we) begin
         mem[b_addr] <= b_wdata;
      end
      a_rdata_q <= mem[a_addr];
      b_rdata_q <= mem[b_addr];
   end

   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;

endmodule

// File: rtl/instruction_cache_way.sv
// One cache way: tag RAM, data RAM and the tag comparator for the looked-up set.
module instruction_cache_way #(
   parameter int TAG_WIDTH   = 20,
   parameter int LINE_WIDTH  = 128,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                   clock,
   input  logic [INDEX_WIDTH-1:0] index,
   input  logic                   write_en,
   input  logic [TAG_WIDTH-1:0]   write_tag,
   input  logic [LINE_WIDTH-1:0]  write_data,
   input  logic [TAG_WIDTH-1:0]   lookup_tag,
   output logic                   tag_match,
   output logic [LINE_WIDTH-1:0]  read_data
);

   logic [TAG_WIDTH-1:0]  stored_tag;
   logic [TAG_WIDTH-1:0]  tag_b_unused;
   logic [LINE_WIDTH-1:0] data_b_unused;

   dual_port_ram_mf #(
      .DATA_WIDTH (TAG_WIDTH),
      .ADDR_WIDTH (INDEX_WIDTH)
   ) u_tag_ram (
      .clock   (clock),
      .a_addr  (index),
      .a_we    (write_en),
      .a_wdata (write_tag),
      .a_rdata (stored_tag),
      .b_addr  ('0),
      .b_we    (1'b0),
      .b_wdata ('0),
      .b_rdata (tag_b_unused)
   );

   dual_port_ram_mf #(
      .DATA_WIDTH (LINE_WIDTH),
      .ADDR_WIDTH (INDEX_WIDTH)
   ) u_data_ram (
      .clock   (clock),
      .a_addr  (index),
      .a_we    (write_en),
      .a_wdata (write_data),
      .a_rdata (read_data),
      .b_addr  ('0),
      .b_we    (1'b0),
      .b_wdata ('0),
      .b_rdata (data_b_unused)
   );

   assign tag_match = (stored_tag == lookup_tag);

endmodule

// File: rtl/instruction_cache_assoc.sv
// N-way set-associative instruction cache: one-cycle hits, blocking miss FSM
// with fill handshake, invalid-first then round-robin replacement, single-cycle flush.
module instruction_cache_assoc
   import instruction_cache_assoc_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int LINE_WIDTH   = 128,
   parameter int INDEX_WIDTH  = 8,
   parameter int OFFSET_WIDTH = 4,
   parameter int WAYS         = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   instruction_cache_assoc_if.slave bus
);

   localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
   localparam int WAY_BITS  = way_index_width(WAYS);
   localparam int SETS      = 1 << INDEX_WIDTH;
   localparam int LINE_BITS = ADDR_WIDTH - OFFSET_WIDTH;

   state_t                state_q, state_d;
   logic [LINE_BITS-1:0]  line_q, line_d;
   logic [LINE_WIDTH-1:0] fill_line_q, fill_line_d;
   logic [WAYS-1:0]       valid_q [SETS];
   logic [WAYS-1:0]       valid_d [SETS];
   logic [WAY_BITS-1:0]   rr_q [SETS];
   logic [WAY_BITS-1:0]   rr_d [SETS];
   logic                  drop_fill_q, drop_fill_d;

   logic [TAG_WIDTH-1:0]    cur_tag;
   logic [INDEX_WIDTH-1:0]  cur_index;
   logic [INDEX_WIDTH-1:0]  req_index;
   logic [INDEX_WIDTH-1:0]  ram_index;
   logic [OFFSET_WIDTH-1:0] offset_unused;
   logic [WAYS-1:0]         tag_match;
   logic [WAYS-1:0]         hit_vec;
   logic [WAYS-1:0]         ram_we;
   logic [LINE_WIDTH-1:0]   way_data [WAYS];
   logic [LINE_WIDTH-1:0]   hit_data;
   logic                    lookup_hit;
   logic                    accept;
   logic                    fill_fire;
   logic [WAY_BITS-1:0]     victim;
   logic [WAY_BITS-1:0]     rr_next;
   logic                    found_invalid;

   logic                    req_ready;
   logic                    resp_valid;
   logic                    resp_hit;
   logic [LINE_WIDTH-1:0]   resp_data;
   logic                    fill_request;
   logic [ADDR_WIDTH-1:0]   fill_address;

   assign cur_tag       = line_q[LINE_BITS-1 -: TAG_WIDTH];
   assign cur_index     = line_q[INDEX_WIDTH-1:0];
   assign req_index     = bus.req_address[OFFSET_WIDTH +: INDEX_WIDTH];
   assign offset_unused = bus.req_address[OFFSET_WIDTH-1:0];
   assign accept        = bus.req_valid && req_ready;
   assign fill_fire     = (state_q == MISS) && bus.fill_valid;
   assign ram_index     = accept ? req_index : cur_index;
   assign hit_vec       = tag_match & valid_q[cur_index];
   assign lookup_hit    = (state_q == LOOKUP) && (|hit_vec) && !bus.flush;
   assign rr_next       = (rr_q[cur_index] == WAY_BITS'(WAYS - 1)) ? '0
                                                                   : rr_q[cur_index] + WAY_BITS'(1);

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      instruction_cache_way #(
         .TAG_WIDTH   (TAG_WIDTH),
         .LINE_WIDTH  (LINE_WIDTH),
         .INDEX_WIDTH (INDEX_WIDTH)
      ) u_way (
         .clock      (clock),
         .index      (ram_index),
         .write_en   (ram_we[w]),
         .write_tag  (cur_tag),
         .write_data (bus.fill_data),
         .lookup_tag (cur_tag),
         .tag_match  (tag_match[w]),
         .read_data  (way_data[w])
      );
   end

   // Lowest-numbered way wins should more than one ever match.
   always_comb begin
      hit_data = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) begin
            hit_data = way_data[w];
         end
      end
   end

   always_comb begin
      victim        = rr_q[cur_index];
      found_invalid = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found_invalid && !valid_q[cur_index][w]) begin
            victim        = WAY_BITS'(w);
            found_invalid = 1'b1;
         end
      end
   end

   always_comb begin
      ram_we = '0;
      for (int w = 0; w < WAYS; w++) begin
         ram_we[w] = fill_fire && (victim == WAY_BITS'(w));
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         line_q      <= '0;
         fill_line_q <= '0;
         valid_q     <= '{default: '0};
         rr_q        <= '{default: '0};
         drop_fill_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         fill_line_q <= fill_line_d;
         valid_q     <= valid_d;
         rr_q        <= rr_d;
         drop_fill_q <= drop_fill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = LOOKUP;
         LOOKUP:  if (!lookup_hit) state_d = MISS;
                  else if (!accept) state_d = IDLE;
         MISS:    if (bus.fill_valid) state_d = RESPOND;
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A flush seen while a miss is outstanding makes that fill return-only.
   always_comb begin
      line_d      = line_q;
      fill_line_d = fill_line_q;
      valid_d     = valid_q;
      rr_d        = rr_q;
      drop_fill_d = (state_q == MISS) && (drop_fill_q || bus.flush);
      if (accept) begin
         line_d = bus.req_address[ADDR_WIDTH-1:OFFSET_WIDTH];
      end
      if (fill_fire) begin
         fill_line_d = bus.fill_data;
         if (!drop_fill_q) begin
            valid_d[cur_index][victim] = 1'b1;
            rr_d[cur_index]            = rr_next;
         end
      end
      if (bus.flush) begin
         for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
            rr_d[s]    = '0;
         end
      end
   end

   always_comb begin
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_hit     = 1'b0;
      resp_data    = '0;
      fill_request = 1'b0;
      fill_address = '0;
      case (state_q)
         IDLE: req_ready = reset_n;
         LOOKUP: begin
            if (lookup_hit) begin
               resp_valid = 1'b1;
               resp_hit   = 1'b1;
               resp_data  = hit_data;
               req_ready  = reset_n;
            end
         end
         MISS: begin
            fill_request = 1'b1;
            fill_address = {line_q, {OFFSET_WIDTH{1'b0}}};
         end
         RESPOND: begin
            resp_valid = 1'b1;
            resp_data  = fill_line_q;
         end
         default: ;
      endcase
   end

   assign bus.req_ready    = req_ready;
   assign bus.resp_valid   = resp_valid;
   assign bus.resp_hit     = resp_hit;
   assign bus.resp_data    = resp_data;
   assign bus.fill_request = fill_request;
   assign bus.fill_address = fill_address;

endmodule
